mm_dispatch: RTL

Front-end for the matrix-multiply stage: accepts 128-bit MM instructions over a valid/ready handshake and checks them. For each legal instruction it pulses `start_valid` into `mm_main` and holds every parameter port stable until `mm_main` raises `done`. It then returns a tagged completion record with a busy-cycle count. Illegal instructions are rejected with an error code and never reach `mm_main`.

---
 rtl/mm_pkg.sv | 63 ++++++
 rtl/mm_inst_decode.sv | 38 +++
 rtl/mm_dispatch.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply dispatcher: instruction layout,
// FSM state encoding, error codes and the fields record handed to mm_main.
package mm_pkg;

   localparam logic [3:0] OPCODE_MM = 4'h3;

   localparam int OPC_LSB   = 0;
   localparam int OPC_W     = 4;
   localparam int WADDR_LSB = 4;
   localparam int WADDR_W   = 13;
   localparam int IADDR_LSB = 17;
   localparam int IADDR_W   = 11;
   localparam int OADDR_LSB = 28;
   localparam int OADDR_W   = 11;
   localparam int BADDR_LSB = 39;
   localparam int BADDR_W   = 9;
   localparam int CI_LSB    = 48;
   localparam int CI_W      = 8;
   localparam int CO_LSB    = 56;
   localparam int CO_W      = 8;
   localparam int N_LSB     = 64;
   localparam int N_W       = 16;
   localparam int R_BIT     = 80;
   localparam int A_BIT     = 81;
   localparam int B_BIT     = 82;
   localparam int RSV_LSB   = 83;
   localparam int RSV_W     = 37;
   localparam int TAG_LSB   = 120;
   localparam int TAG_W     = 8;

   localparam logic [2:0] ERR_NONE          = 3'd0;
   localparam logic [2:0] ERR_OPCODE        = 3'd1;
   localparam logic [2:0] ERR_ZERO_DIM      = 3'd2;
   localparam logic [2:0] ERR_SPURIOUS_DONE = 3'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_CMPL   = 3'd4,
      ST_ERR    = 3'd5
   } mm_state_t;

   typedef struct packed {
      logic [WADDR_W-1:0] weight_addr;
      logic [IADDR_W-1:0] input_addr;
      logic [OADDR_W-1:0] output_addr;
      logic [BADDR_W-1:0] bias_addr;
      logic [CI_W-1:0]    ci;
      logic [CO_W-1:0]    co;
      logic [N_W-1:0]     n;
      logic               relu;
      logic               acc;
      logic               bias;
      logic [TAG_W-1:0]   tag;
   } mm_fields_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/mm_inst_decode.sv
// Combinational field extraction and legality check for one MM instruction.
module mm_inst_decode
   import mm_pkg::*;
#(
   parameter int INST_W = 128
) (
   input  logic [INST_W-1:0] inst,
   output mm_fields_t        fields,
   output logic [2:0]        err_code
);

   // Reserved bits carry no meaning; folded here so they are visibly consumed.
   logic unused_reserved;
   assign unused_reserved = ^inst[RSV_LSB +: RSV_W];

   always_comb begin
      fields             = '0;
      fields.weight_addr = inst[WADDR_LSB +: WADDR_W];
      fields.input_addr  = inst[IADDR_LSB +: IADDR_W];
      fields.output_addr = inst[OADDR_LSB +: OADDR_W];
      fields.bias_addr   = inst[BADDR_LSB +: BADDR_W];
      fields.ci          = inst[CI_LSB +: CI_W];
      fields.co          = inst[CO_LSB +: CO_W];
      fields.n           = inst[N_LSB +: N_W];
      fields.relu        = inst[R_BIT];
      fields.acc         = inst[A_BIT];
      fields.bias        = inst[B_BIT];
      fields.tag         = inst[TAG_LSB +: TAG_W];

      err_code = ERR_NONE;
      if (inst[OPC_LSB +: OPC_W] != OPCODE_MM) begin
         err_code = ERR_OPCODE;
      end else if (fields.ci == '0 || fields.co == '0 || fields.n == '0) begin
         err_code = ERR_ZERO_DIM;
      end
   end

endmodule

// File: rtl/mm_dispatch.sv
// Matrix-multiply front-end: accepts one instruction at a time, validates it,
// starts mm_main, and reports a tagged completion or an error.
//
// state  | meaning
// IDLE   | ready for a new instruction
// DECODE | fields latched, legality result being acted on
// START  | one-cycle start pulse to mm_main, busy counter cleared
// WAIT   | mm_main running, busy counter counting
// CMPL   | completion pulse with tag and cycle count
// ERR    | rejected instruction reported with code and tag
module mm_dispatch
   import mm_pkg::*;
#(
   parameter int INST_W = 128
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              inst_valid,
   output logic              inst_ready,
   input  logic [INST_W-1:0] inst_data,
   output logic              mm_start_valid,
   output logic [12:0]       mm_weight_start_addr,
   output logic [10:0]       mm_input_start_addr,
   output logic [10:0]       mm_output_start_addr,
   output logic [8:0]        mm_bias_start_addr,
   output logic [7:0]        mm_input_addr_per_feature,
   output logic [7:0]        mm_output_addr_per_feature,
   output logic [15:0]       mm_number_of_node,
   output logic              mm_r,
   output logic              mm_a,
   output logic              mm_b,
   input  logic              mm_done,
   output logic              cmpl_valid,
   output logic [7:0]        cmpl_tag,
   output logic [31:0]       cmpl_cycles,
   output logic              err_valid,
   output logic [2:0]        err_code,
   output logic [7:0]        err_tag
);

   mm_state_t  state, state_nxt;
   mm_fields_t fields_d, params_q;
   logic [2:0] dec_code, dec_code_q;
   logic [31:0] busy_cnt;
   logic        accept;

   mm_inst_decode #(.INST_W(INST_W)) u_decode (
      .inst     (inst_data),
      .fields   (fields_d),
      .err_code (dec_code)
   );

   assign accept = inst_valid & inst_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (inst_valid) state_nxt = ST_DECODE;
         ST_DECODE: state_nxt = (dec_code_q != ERR_NONE) ? ST_ERR : ST_START;
         ST_START:  state_nxt = ST_WAIT;
         ST_WAIT:   if (mm_done) state_nxt = ST_CMPL;
         ST_CMPL:   state_nxt = ST_IDLE;
         ST_ERR:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      inst_ready     = (state == ST_IDLE);
      mm_start_valid = (state == ST_START);
      cmpl_valid     = (state == ST_CMPL);
   end

   // Parameters only move on accept, so mm_main sees them stable for the whole run.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         params_q   <= '0;
         dec_code_q <= ERR_NONE;
      end else if (accept) begin
         params_q   <= fields_d;
         dec_code_q <= dec_code;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_cnt    <= '0;
         cmpl_tag    <= '0;
         cmpl_cycles <= '0;
      end else begin
         if (state == ST_START)     busy_cnt <= '0;
         else if (state == ST_WAIT) busy_cnt <= sat_inc32(busy_cnt);
         if (state == ST_WAIT && mm_done) begin
            cmpl_tag    <= params_q.tag;
            cmpl_cycles <= sat_inc32(busy_cnt);
         end
      end
   end

   // A decode rejection outranks a spurious done landing in the same cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_valid <= 1'b0;
         err_code  <= ERR_NONE;
         err_tag   <= '0;
      end else if (state == ST_DECODE && dec_code_q != ERR_NONE) begin
         err_valid <= 1'b1;
         err_code  <= dec_code_q;
         err_tag   <= params_q.tag;
      end else if (mm_done && state != ST_WAIT) begin
         err_valid <= 1'b1;
         err_code  <= ERR_SPURIOUS_DONE;
         err_tag   <= '0;
      end else begin
         err_valid <= 1'b0;
      end
   end

   assign mm_weight_start_addr       = params_q.weight_addr;
   assign mm_input_start_addr        = params_q.input_addr;
   assign mm_output_start_addr       = params_q.output_addr;
   assign mm_bias_start_addr         = params_q.bias_addr;
   assign mm_input_addr_per_feature  = params_q.ci;
   assign mm_output_addr_per_feature = params_q.co;
   assign mm_number_of_node          = params_q.n;
   assign mm_r                       = params_q.relu;
   assign mm_a                       = params_q.acc;
   assign mm_b                       = params_q.bias;

endmodule
